// File: rtl/report_dump_scheduler.sv
// Shared report-BRAM port scheduler: record writes always win, readout streams 9-byte frames.
// Latency: one record = FETCH, WAIT, 9 SEND, NEXT = 12 cycles; tx_data/tx_valid held while tx_ready=0.
module report_dump_scheduler #(
    parameter int         ADDR_W = 16,
    parameter logic [7:0] HDR0   = 8'h5B,
    parameter logic [7:0] HDR1   = 8'h5C,
    parameter logic [7:0] HDR2   = 8'h5D,
    parameter logic [7:0] TRAIL  = 8'h0A
) (
    input  logic              CLK,
    input  logic              CPU_RESETN,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rec_count,
    input  logic              dump_start,
    input  logic              dump_abort,
    input  logic [7:0]        rd_b1,
    input  logic [7:0]        rd_b2,
    input  logic [7:0]        rd_b3,
    input  logic [7:0]        rd_word,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    output logic              bram_we,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              dump_busy,
    output logic              dump_done
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SEND, S_NEXT} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [3:0]          byte_idx_q, byte_idx_d;
    logic [7:0]          b1_q, b1_d, b2_q, b2_d, b3_q, b3_d, word_q, word_d, addr_lo_q, addr_lo_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                start_ok;
    logic                accept;
    logic                last_rec;
    logic [3:0]          nidx;
    logic [7:0]          nxt_byte;

    assign start_ok = dump_start && !dump_abort;
    assign accept   = tx_valid_q && tx_ready;
    // rec_count is live: a shrink below rd_ptr+1 also terminates the dump
    assign last_rec = ({1'b0, rd_ptr_q} + {{ADDR_W{1'b0}}, 1'b1}) >= {1'b0, rec_count};

    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            byte_idx_q <= '0;
            b1_q       <= '0;
            b2_q       <= '0;
            b3_q       <= '0;
            word_q     <= '0;
            addr_lo_q  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            byte_idx_q <= byte_idx_d;
            b1_q       <= b1_d;
            b2_q       <= b2_d;
            b3_q       <= b3_d;
            word_q     <= word_d;
            addr_lo_q  <= addr_lo_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_ok && rec_count != '0) state_d = S_FETCH;
            S_FETCH: if (!wr_req) state_d = S_WAIT;
            S_WAIT:  state_d = S_SEND;
            S_SEND:  if (accept && byte_idx_q == 4'd8) state_d = S_NEXT;
            S_NEXT:  state_d = last_rec ? S_IDLE : S_FETCH;
            default: state_d = S_IDLE;
        endcase
        if (dump_abort) state_d = S_IDLE;
    end

    always_comb begin
        nidx = byte_idx_q + 4'd1;
        case (nidx)
            4'd1:    nxt_byte = b1_q;
            4'd2:    nxt_byte = HDR1;
            4'd3:    nxt_byte = b2_q;
            4'd4:    nxt_byte = b3_q;
            4'd5:    nxt_byte = HDR2;
            4'd6:    nxt_byte = word_q;
            4'd7:    nxt_byte = addr_lo_q;
            4'd8:    nxt_byte = TRAIL;
            default: nxt_byte = HDR0;
        endcase
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        byte_idx_d = byte_idx_q;
        b1_d       = b1_q;
        b2_d       = b2_q;
        b3_d       = b3_q;
        word_d     = word_q;
        addr_lo_d  = addr_lo_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    if (rec_count != '0) begin
                        rd_ptr_d = '0;
                        busy_d   = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Read was issued last cycle, so capture is safe even if a write owns the port now
                b1_d       = rd_b1;
                b2_d       = rd_b2;
                b3_d       = rd_b3;
                word_d     = rd_word;
                addr_lo_d  = rd_ptr_q[7:0];
                byte_idx_d = 4'd0;
                tx_data_d  = HDR0;
                tx_valid_d = 1'b1;
            end
            S_SEND: begin
                if (accept) begin
                    if (byte_idx_q == 4'd8) begin
                        tx_valid_d = 1'b0;
                    end else begin
                        byte_idx_d = nidx;
                        tx_data_d  = nxt_byte;
                    end
                end
            end
            S_NEXT: begin
                if (last_rec) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    rd_ptr_d = rd_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            default: ;
        endcase

        if (dump_abort && state_q != S_IDLE) begin
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
        end
    end

    always_comb begin
        bram_addr = rd_ptr_q;
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        if (wr_req) begin
            bram_addr = wr_addr;
            bram_en   = 1'b1;
            bram_we   = 1'b1;
        end else if (state_q == S_FETCH) begin
            bram_en = 1'b1;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign dump_busy = busy_q;
    assign dump_done = done_q;

endmodule

// File: tb/tb_report_dump_scheduler.sv
// Directed bench for report_dump_scheduler with a read-only BRAM model and a byte collector.
module tb_report_dump_scheduler;

    localparam int AW = 16;

    logic          CLK = 1'b0;
    logic          CPU_RESETN;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rec_count;
    logic          dump_start;
    logic          dump_abort;
    logic [7:0]    rd_b1, rd_b2, rd_b3, rd_word;
    logic [AW-1:0] bram_addr;
    logic          bram_en, bram_we;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          dump_busy, dump_done;

    always #5 CLK = ~CLK;

    report_dump_scheduler #(.ADDR_W(AW)) dut (
        .CLK        (CLK),
        .CPU_RESETN (CPU_RESETN),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .rec_count  (rec_count),
        .dump_start (dump_start),
        .dump_abort (dump_abort),
        .rd_b1      (rd_b1),
        .rd_b2      (rd_b2),
        .rd_b3      (rd_b3),
        .rd_word    (rd_word),
        .bram_addr  (bram_addr),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] m_b1 [0:255];
    logic [7:0] m_b2 [0:255];
    logic [7:0] m_b3 [0:255];
    logic [7:0] m_wd [0:255];

    initial begin
        for (int i = 0; i < 256; i++) begin
            m_b1[i] = 8'h00; m_b2[i] = 8'h00; m_b3[i] = 8'h00; m_wd[i] = 8'h00;
        end
        m_b1[0] = 8'h01; m_b2[0] = 8'h02; m_b3[0] = 8'h03; m_wd[0] = 8'hAA;
        m_b1[1] = 8'h04; m_b2[1] = 8'h05; m_b3[1] = 8'h06; m_wd[1] = 8'hBB;
    end

    always @(posedge CLK) begin
        if (bram_en && !bram_we) begin
            rd_b1   <= m_b1[bram_addr[7:0]];
            rd_b2   <= m_b2[bram_addr[7:0]];
            rd_b3   <= m_b3[bram_addr[7:0]];
            rd_word <= m_wd[bram_addr[7:0]];
        end
    end

    logic [7:0] exp_b [18] = '{8'h5B, 8'h01, 8'h5C, 8'h02, 8'h03, 8'h5D, 8'hAA, 8'h00, 8'h0A,
                               8'h5B, 8'h04, 8'h5C, 8'h05, 8'h06, 8'h5D, 8'hBB, 8'h01, 8'h0A};

    int         cyc = 0;
    bit         rdy_mode = 1'b0;
    bit         chk_stable = 1'b0;
    logic [7:0] rx_q [$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         en_cnt = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_dat = 8'h00;

    always @(negedge CLK) begin
        if (chk_stable && prev_stall) begin
            check_vec("hold_valid", 32'(tx_valid), 32'd1);
            check_vec("hold_data", 32'(tx_data), 32'(prev_dat));
        end
        prev_stall = tx_valid && !tx_ready;
        prev_dat   = tx_data;
        if (tx_valid && tx_ready) rx_q.push_back(tx_data);
        if (dump_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bram_en && !bram_we) en_cnt++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (rdy_mode) tx_ready = (cyc % 3 == 0);
    endtask

    task automatic start_dump(output int s);
        tick();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) tick();
        check_vec("done_seen", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic compare_frame(input string tag, input int base);
        int n;
        n = rx_q.size() - base;
        check_vec({tag, "_nbytes"}, 32'(n), 32'd18);
        for (int i = 0; i < 18 && i < n; i++)
            check_vec($sformatf("%s_byte%0d", tag, i), 32'(rx_q[base+i]), 32'(exp_b[i]));
    endtask

    initial begin
        int s, base, d0, e0;
        CPU_RESETN = 1'b0;
        wr_req = 1'b0; wr_addr = '0; rec_count = '0;
        dump_start = 1'b0; dump_abort = 1'b0; tx_ready = 1'b1;
        #1;
        check_vec("rst_addr", 32'(bram_addr), 32'd0);
        check_vec("rst_en", 32'(bram_en), 32'd0);
        check_vec("rst_we", 32'(bram_we), 32'd0);
        check_vec("rst_txd", 32'(tx_data), 32'd0);
        check_vec("rst_txv", 32'(tx_valid), 32'd0);
        check_vec("rst_busy", 32'(dump_busy), 32'd0);
        check_vec("rst_done", 32'(dump_done), 32'd0);
        tick(); tick();
        CPU_RESETN = 1'b1;
        tick();

        // two-record dump, ready always high
        rec_count = 16'd2;
        base = rx_q.size();
        start_dump(s);
        check_vec("busy_after_start", 32'(dump_busy), 32'd1);
        wait_done(60);
        check_vec("done_latency", 32'(done_cyc - s), 32'd24);
        check_vec("busy_after_done", 32'(dump_busy), 32'd0);
        compare_frame("basic", base);

        // ready high one cycle in three
        rdy_mode = 1'b1;
        chk_stable = 1'b1;
        base = rx_q.size();
        start_dump(s);
        wait_done(200);
        compare_frame("stall", base);
        chk_stable = 1'b0;
        rdy_mode = 1'b0;
        tx_ready = 1'b1;
        tick(); tick();

        // write held 5 cycles across FETCH of record 1
        base = rx_q.size();
        start_dump(s);
        repeat (12) tick();
        for (int i = 0; i < 5; i++) begin
            wr_req = 1'b1;
            wr_addr = 16'd7;
            #1;
            check_vec($sformatf("wr_we%0d", i), 32'(bram_we), 32'd1);
            check_vec($sformatf("wr_addr%0d", i), 32'(bram_addr), 32'd7);
            check_vec($sformatf("wr_txv%0d", i), 32'(tx_valid), 32'd0);
            tick();
        end
        wr_req = 1'b0;
        #1;
        check_vec("rd_issue_en", 32'(bram_en), 32'd1);
        check_vec("rd_issue_we", 32'(bram_we), 32'd0);
        check_vec("rd_issue_addr", 32'(bram_addr), 32'd1);
        wait_done(80);
        check_vec("wr_done_latency", 32'(done_cyc - s), 32'd29);
        compare_frame("wr", base);

        // abort while byte 4 of record 0 is presented
        start_dump(s);
        repeat (6) tick();
        check_vec("abort_pre_txd", 32'(tx_data), 32'h03);
        dump_abort = 1'b1;
        tick();
        dump_abort = 1'b0;
        check_vec("abort_txv", 32'(tx_valid), 32'd0);
        check_vec("abort_busy", 32'(dump_busy), 32'd0);
        d0 = done_cnt;
        repeat (20) tick();
        check_vec("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check_vec("abort_idle_txv", 32'(tx_valid), 32'd0);
        base = rx_q.size();
        start_dump(s);
        wait_done(60);
        compare_frame("restart", base);

        // empty dump
        rec_count = 16'd0;
        tick();
        base = rx_q.size(); e0 = en_cnt; d0 = done_cnt;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        check_vec("empty_done", 32'(dump_done), 32'd1);
        check_vec("empty_busy", 32'(dump_busy), 32'd0);
        tick();
        check_vec("empty_done_pulse", 32'(dump_done), 32'd0);
        repeat (5) tick();
        check_vec("empty_nbytes", 32'(rx_q.size() - base), 32'd0);
        check_vec("empty_reads", 32'(en_cnt - e0), 32'd0);
        check_vec("empty_done_cnt", 32'(done_cnt - d0), 32'd1);

        // reset in the middle of SEND
        rec_count = 16'd2;
        start_dump(s);
        repeat (3) tick();
        check_vec("mid_send_txv", 32'(tx_valid), 32'd1);
        #2;
        CPU_RESETN = 1'b0;
        #1;
        check_vec("arst_txv", 32'(tx_valid), 32'd0);
        check_vec("arst_txd", 32'(tx_data), 32'd0);
        check_vec("arst_busy", 32'(dump_busy), 32'd0);
        check_vec("arst_en", 32'(bram_en), 32'd0);
        check_vec("arst_addr", 32'(bram_addr), 32'd0);
        tick(); tick();
        CPU_RESETN = 1'b1;
        base = rx_q.size();
        repeat (30) tick();
        check_vec("post_rst_nbytes", 32'(rx_q.size() - base), 32'd0);
        check_vec("post_rst_busy", 32'(dump_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
